// File: rtl/tx_fifo_fsm.sv
// Buffered UART transmitter: a valid/ready write port feeds a small FIFO,
// and a framing FSM serialises queued bytes back-to-back onto TX.
module tx_fifo_fsm #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 RSTn,
  input  logic [DATA_BITS-1:0]                 data_in,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  output logic                                 TX,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam int unsigned SW = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  state_t               state;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic [SW-1:0]        stop_idx;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 have_data;
  logic                 bit_done;
  logic                 stop_last;
  logic [DATA_BITS-1:0] head;

  // Handshake and pop decisions; full is judged on the registered count only.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign wr_ready   = ~full;
  assign push       = wr_valid & ~full;
  assign have_data  = (count != '0);
  assign bit_done   = (baud == BW'(CLKS_PER_BIT - 1));
  assign stop_last  = bit_done & (stop_idx == SW'(STOP_BITS - 1));
  assign pop        = have_data & ((state == IDLE) | ((state == STOP) & stop_last));
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // FIFO storage; contents need no reset since pointers/count gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Framing FSM with registered TX/busy.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state      <= IDLE;
      TX         <= 1'b1;
      busy       <= 1'b0;
      shifter    <= '0;
      parity_bit <= 1'b0;
      baud       <= '0;
      bit_idx    <= '0;
      stop_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          TX   <= 1'b1;
          baud <= '0;
          if (have_data) begin
            shifter    <= head;
            parity_bit <= (^head) ^ 1'(PARITY_ODD);
            TX         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud    <= '0;
            TX      <= shifter[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            baud <= '0;
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                TX    <= parity_bit;
                state <= PARITY;
              end else begin
                TX       <= 1'b1;
                stop_idx <= '0;
                state    <= STOP;
              end
            end else begin
              TX      <= shifter[1];
              shifter <= shifter >> 1;
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            baud     <= '0;
            TX       <= 1'b1;
            stop_idx <= '0;
            state    <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end

        STOP: begin
          TX <= 1'b1;
          if (bit_done) begin
            baud <= '0;
            if (stop_last) begin
              stop_idx <= '0;
              // Back-to-back: next frame's start bit begins with no idle gap.
              if (have_data) begin
                shifter    <= head;
                parity_bit <= (^head) ^ 1'(PARITY_ODD);
                TX         <= 1'b0;
                state      <= START;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + SW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end

        default: begin
          TX    <= 1'b1;
          busy  <= 1'b0;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
